// File: rtl/seg_scan_if.sv
// Bus between a digit-scan controller and the logic that feeds it frames and consumes
// the per-digit code, active-low select and decimal point.
interface seg_scan_if #(
  parameter int NUM_DIG = 6
) ();
  logic                   en;
  logic                   lz_en;
  logic                   load;
  logic [4*NUM_DIG-1:0]   data_in;
  logic [NUM_DIG-1:0]     dp_in;
  logic [3:0]             bin_data;
  logic [NUM_DIG-1:0]     sel_n;
  logic                   dp_n;
  logic                   frame_done;

  modport master (
    output en, lz_en, load, data_in, dp_in,
    input  bin_data, sel_n, dp_n, frame_done
  );

  modport slave (
    input  en, lz_en, load, data_in, dp_in,
    output bin_data, sel_n, dp_n, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller: one digit lit per slot with a
// dead-time gap, double-buffered frame data and optional leading-zero blanking.
module seg_scan_ctrl #(
  parameter int NUM_DIG   = 6,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic     clk_i,
  input  logic     rst_i,
  seg_scan_if.slave bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIG - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [NUM_DIG-1:0][3:0]   disp_code_q, disp_code_d;
  logic [NUM_DIG-1:0]        disp_dp_q, disp_dp_d;
  logic [NUM_DIG-1:0][3:0]   shad_code_q, shad_code_d;
  logic [NUM_DIG-1:0]        shad_dp_q, shad_dp_d;
  logic                      pending_q, pending_d;
  logic [3:0]                bin_data_q, bin_data_d;
  logic [NUM_DIG-1:0]        sel_n_q, sel_n_d;
  logic                      dp_n_q, dp_n_d;
  logic                      frame_done_q, frame_done_d;
  logic                      boundary_s;
  logic [NUM_DIG-1:0]        blank_s;

  // A digit above 0 goes dark while it and everything to its left is a plain zero.
  function automatic logic [NUM_DIG-1:0] lz_mask(
    input logic [NUM_DIG-1:0][3:0] code,
    input logic [NUM_DIG-1:0]      dp,
    input logic                    lz
  );
    logic [NUM_DIG-1:0] mask;
    logic               zero_above;
    mask       = {NUM_DIG{1'b0}};
    zero_above = 1'b1;
    for (int k = NUM_DIG - 1; k > 0; k--) begin
      zero_above = zero_above & (code[k] == 4'd0) & ~dp[k];
      mask[k]    = lz & zero_above;
    end
    return mask;
  endfunction

  // Slot sequencer: blank dead-time, then on-time, then advance to the next digit.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    boundary_s = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      idx_d   = {IW{1'b0}};
      cnt_d   = {CW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = {IW{1'b0}};
          cnt_d   = {CW{1'b0}};
        end
        BLANK: begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == BLANK_LAST) ? ON : BLANK;
        end
        ON: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = BLANK;
            cnt_d   = {CW{1'b0}};
            if (idx_q == IDX_LAST) begin
              idx_d      = {IW{1'b0}};
              boundary_s = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = {IW{1'b0}};
          cnt_d   = {CW{1'b0}};
        end
      endcase
    end
  end

  // Double buffer: loads land in the shadow, which only reaches the display at a frame edge.
  always_comb begin
    shad_code_d = bus.load ? bus.data_in : shad_code_q;
    shad_dp_d   = bus.load ? bus.dp_in   : shad_dp_q;
    pending_d   = bus.load | (pending_q & ~boundary_s);
    if (boundary_s && pending_q) begin
      disp_code_d = shad_code_q;
      disp_dp_d   = shad_dp_q;
    end else begin
      disp_code_d = disp_code_q;
      disp_dp_d   = disp_dp_q;
    end
  end

  // Pin values are derived from the next state so they change on the same edge as the FSM.
  always_comb begin
    blank_s      = lz_mask(disp_code_d, disp_dp_d, bus.lz_en);
    sel_n_d      = {NUM_DIG{1'b1}};
    dp_n_d       = 1'b1;
    bin_data_d   = bin_data_q;
    frame_done_d = boundary_s;
    for (int k = 0; k < NUM_DIG; k++) begin
      if ((state_d == ON) && (idx_d == IW'(k)) && !blank_s[k]) begin
        sel_n_d[k] = 1'b0;
        dp_n_d     = ~disp_dp_d[k];
      end else begin
        sel_n_d[k] = 1'b1;
      end
      // The code is latched as the slot's blank period starts, ahead of the select.
      if ((state_d == BLANK) && (state_q != BLANK) && (idx_d == IW'(k))) begin
        bin_data_d = disp_code_d[k];
      end else begin
        bin_data_d = bin_data_d;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      idx_q        <= {IW{1'b0}};
      cnt_q        <= {CW{1'b0}};
      disp_code_q  <= {(4*NUM_DIG){1'b0}};
      disp_dp_q    <= {NUM_DIG{1'b0}};
      shad_code_q  <= {(4*NUM_DIG){1'b0}};
      shad_dp_q    <= {NUM_DIG{1'b0}};
      pending_q    <= 1'b0;
      bin_data_q   <= 4'd0;
      sel_n_q      <= {NUM_DIG{1'b1}};
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_code_q  <= disp_code_d;
      disp_dp_q    <= disp_dp_d;
      shad_code_q  <= shad_code_d;
      shad_dp_q    <= shad_dp_d;
      pending_q    <= pending_d;
      bin_data_q   <= bin_data_d;
      sel_n_q      <= sel_n_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.bin_data   = bin_data_q;
  assign bus.sel_n      = sel_n_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 8-cycle slots and 2 blank cycles.
module tb_seg_scan_ctrl;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seg_scan_if #(.NUM_DIG(ND)) bus ();

  seg_scan_ctrl #(.NUM_DIG(ND), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic        lz;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  e_sel;
    logic        e_dp;
    logic [3:0]  e_bin;
    logic        e_fd;
  } vec_t;

  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [3:0] e_sel, input logic e_dp,
                            input logic [3:0] e_bin, input logic e_fd, input bit chk_bin);
    checks++;
    if (bus.sel_n !== e_sel || bus.dp_n !== e_dp || bus.frame_done !== e_fd ||
        (chk_bin && bus.bin_data !== e_bin)) begin
      errors++;
      $display("FAIL %s: got sel_n=%b dp_n=%b bin=%h fd=%b, want sel_n=%b dp_n=%b bin=%h fd=%b",
               name, bus.sel_n, bus.dp_n, bus.bin_data, bus.frame_done,
               e_sel, e_dp, e_bin, e_fd);
    end
  endtask

  task automatic arm_load(input logic [15:0] data, input logic [3:0] dp);
    bus.load    = 1'b1;
    bus.data_in = data;
    bus.dp_in   = dp;
  endtask

  // One full 8-cycle slot starting at the edge that enters BLANK for digit dig.
  task automatic check_slot(input int dig, input logic [3:0] code, input bit shown,
                            input bit dp_on, input bit fd0);
    logic lit;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) bus.load = 1'b0;
      lit = (c >= 2) && shown;
      expect_out($sformatf("slot_d%0d_c%0d", dig, c), lit ? ~(4'b0001 << dig) : 4'hF,
                 ~(lit && dp_on), code, (c == 0) ? fd0 : 1'b0, 1'b1);
    end
  endtask

  task automatic check_frame(input logic [15:0] data, input logic [3:0] dp,
                             input logic [3:0] shown, input bit fd0);
    for (int d = 0; d < ND; d++) begin
      check_slot(d, data[4*d +: 4], shown[d], dp[d], (d == 0) ? fd0 : 1'b0);
    end
  endtask

  // Continuous select-safety monitor: at most one digit on, and >=2 dark cycles between digits.
  logic [3:0] prev_sel = 4'hF;
  int         ones_run = 0;
  bit         seen = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_sel = 4'hF;
      ones_run = 0;
      seen     = 1'b0;
    end else begin
      checks++;
      if ($countones(~bus.sel_n) > 1) begin
        errors++;
        $display("FAIL onehot: sel_n=%b has more than one low bit", bus.sel_n);
      end
      if (bus.sel_n == 4'hF) begin
        ones_run++;
      end else begin
        if (bus.sel_n != prev_sel) begin
          if (seen) begin
            checks++;
            if (ones_run < 2) begin
              errors++;
              $display("FAIL gap: %0d dark cycles before sel_n=%b, want >= 2", ones_run, bus.sel_n);
            end
          end
          seen = 1'b1;
        end
        ones_run = 0;
      end
      prev_sel = bus.sel_n;
    end
  end

  initial begin
    bus.en      = 1'b0;
    bus.lz_en   = 1'b0;
    bus.load    = 1'b0;
    bus.data_in = 16'h0000;
    bus.dp_in   = 4'h0;

    //            rst   en    lz    load  data      dp    e_sel  e_dp  e_bin e_fd
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 4'h0, 4'hF, 1'b1, 4'h0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 4'h0, 4'hE, 1'b1, 4'h0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 4'h0, 4'hE, 1'b1, 4'h0, 1'b0};

    for (int i = 0; i < 6; i++) begin
      rst         = tbl[i].rst;
      bus.en      = tbl[i].en;
      bus.lz_en   = tbl[i].lz;
      bus.load    = tbl[i].load;
      bus.data_in = tbl[i].data;
      bus.dp_in   = tbl[i].dp;
      tick();
      expect_out($sformatf("vec%0d", i), tbl[i].e_sel, tbl[i].e_dp, tbl[i].e_bin, tbl[i].e_fd, 1'b1);
    end

    // First frame still shows the all-zero reset display.
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_out("frame0_d0_on", 4'hE, 1'b1, 4'h0, 1'b0, 1'b1);
    end
    check_slot(1, 4'h0, 1'b1, 1'b0, 1'b0);
    check_slot(2, 4'h0, 1'b1, 1'b0, 1'b0);
    check_slot(3, 4'h0, 1'b1, 1'b0, 1'b0);

    // 1234 appears from the first boundary; load 0050 mid-frame for the next one.
    check_slot(0, 4'h4, 1'b1, 1'b0, 1'b1);
    check_slot(1, 4'h3, 1'b1, 1'b0, 1'b0);
    arm_load(16'h0050, 4'h0);
    check_slot(2, 4'h2, 1'b1, 1'b0, 1'b0);
    check_slot(3, 4'h1, 1'b1, 1'b0, 1'b0);

    // Leading-zero blanking of 0050, then 0050 with dp on digit 2.
    bus.lz_en = 1'b1;
    check_slot(0, 4'h0, 1'b1, 1'b0, 1'b1);
    arm_load(16'h0050, 4'b0100);
    check_slot(1, 4'h5, 1'b1, 1'b0, 1'b0);
    check_slot(2, 4'h0, 1'b0, 1'b0, 1'b0);
    check_slot(3, 4'h0, 1'b0, 1'b0, 1'b0);

    // Two loads in one frame: the frame keeps old data, the last load wins next frame.
    check_slot(0, 4'h0, 1'b1, 1'b0, 1'b1);
    arm_load(16'hAAAA, 4'h0);
    check_slot(1, 4'h5, 1'b1, 1'b0, 1'b0);
    check_slot(2, 4'h0, 1'b1, 1'b1, 1'b0);
    arm_load(16'hBBBB, 4'h0);
    check_slot(3, 4'h0, 1'b0, 1'b0, 1'b0);
    check_frame(16'hBBBB, 4'h0, 4'hF, 1'b1);

    // Disable mid-ON of digit 2 with a pending load, then re-enable.
    check_slot(0, 4'hB, 1'b1, 1'b0, 1'b1);
    arm_load(16'h0007, 4'h0);
    check_slot(1, 4'hB, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_out("d2_before_off", (c >= 2) ? 4'hB : 4'hF, 1'b1, 4'hB, 1'b0, 1'b1);
    end
    bus.en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_out("dark", 4'hF, 1'b1, 4'h0, 1'b0, 1'b0);
    end
    bus.en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      expect_out("reenable_d0", (c >= 2) ? 4'hE : 4'hF, 1'b1, 4'hB, 1'b0, 1'b1);
    end
    check_slot(1, 4'hB, 1'b1, 1'b0, 1'b0);
    check_slot(2, 4'hB, 1'b1, 1'b0, 1'b0);
    check_slot(3, 4'hB, 1'b1, 1'b0, 1'b0);

    // Pending 0007 applied after re-enable; reset mid-slot discards a newer pending load.
    check_slot(0, 4'h7, 1'b1, 1'b0, 1'b1);
    arm_load(16'h9999, 4'hF);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 0) bus.load = 1'b0;
      expect_out("d1_blanked", 4'hF, 1'b1, 4'h0, 1'b0, 1'b1);
    end
    rst = 1'b1;
    tick();
    expect_out("reset_mid", 4'hF, 1'b1, 4'h0, 1'b0, 1'b1);
    rst = 1'b0;
    bus.lz_en = 1'b0;
    check_frame(16'h0000, 4'h0, 4'hF, 1'b0);
    check_frame(16'h0000, 4'h0, 4'hF, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
